// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
// Grants one requester at a time for up to MAX_BURST accepted beats, stalling on fifo_full.
module fifo_wr_arbiter #(
    parameter int Width     = 4,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                     wclk,
    input  logic                     wreset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*Width-1:0] req_data,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    input  logic                     fifo_full,
    output logic                     fifo_wen,
    output logic [Width-1:0]         fifo_wdata
);

    localparam int IdxW = $clog2(NUM_REQ);
    localparam int CntW = $clog2(MAX_BURST) + 1;
    localparam logic [IdxW-1:0] LastInit = IdxW'(NUM_REQ - 1);
    localparam logic [CntW-1:0] CntLast  = CntW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t              state, state_nxt;
    logic [IdxW-1:0]     g, g_nxt;
    logic [IdxW-1:0]     last, last_nxt;
    logic [CntW-1:0]     beat_cnt, beat_cnt_nxt;
    logic [NUM_REQ-1:0]  gnt_nxt;
    logic                release_now;

    // First requesting index after base, wrapping modulo NUM_REQ; base itself is checked last.
    function automatic logic [IdxW-1:0] rr_pick(input logic [IdxW-1:0]    base,
                                                input logic [NUM_REQ-1:0] r);
        logic [IdxW-1:0] pick;
        logic [IdxW-1:0] cand;
        logic            found;
        pick  = base;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IdxW'((int'(base) + k) % NUM_REQ);
            if (!found && r[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Handshake is purely combinational from the registered grant, so the FIFO
    // accepts a beat on the same edge its ack is seen.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        ack        = gnt & req & {NUM_REQ{~fifo_full}};
        fifo_wen   = |ack;
        busy       = |gnt;
        fifo_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                fifo_wdata = req_data[i*Width +: Width];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        g_nxt        = g;
        last_nxt     = last;
        beat_cnt_nxt = beat_cnt;
        gnt_nxt      = gnt;
        release_now  = 1'b0;

        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = GRANT;
                    g_nxt     = rr_pick(last, req);
                    gnt_nxt   = NUM_REQ'(1) << g_nxt;
                end
            end

            GRANT: begin
                // Stall cycles never advance the count, so the cap is on accepted beats only.
                release_now = !req[g] || (ack[g] && (beat_cnt == CntLast));
                if (release_now) begin
                    last_nxt     = g;
                    beat_cnt_nxt = '0;
                    if (|req) begin
                        g_nxt   = rr_pick(g, req);
                        gnt_nxt = NUM_REQ'(1) << g_nxt;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                    end
                end else if (ack[g]) begin
                    beat_cnt_nxt = beat_cnt + CntW'(1);
                end
            end

            default: begin
                state_nxt    = IDLE;
                gnt_nxt      = '0;
                beat_cnt_nxt = '0;
            end
        endcase
    end

    // Reset clears the grant asynchronously, so a partial burst is abandoned at once.
    always_ff @(posedge wclk or negedge wreset) begin
        if (!wreset) begin
            state    <= IDLE;
            gnt      <= '0;
            g        <= '0;
            last     <= LastInit;
            beat_cnt <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            g        <= g_nxt;
            last     <= last_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural round-robin model and a write scoreboard.
module tb_fifo_wr_arbiter;

    localparam int W  = 4;
    localparam int NR = 4;
    localparam int MB = 4;

    logic            wclk;
    logic            wreset;
    logic [NR-1:0]   req;
    logic [NR*W-1:0] req_data;
    logic [NR-1:0]   ack;
    logic [NR-1:0]   gnt;
    logic            busy;
    logic            fifo_full;
    logic            fifo_wen;
    logic [W-1:0]    fifo_wdata;

    fifo_wr_arbiter #(.Width(W), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .wclk       (wclk),
        .wreset     (wreset),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .gnt        (gnt),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_wen   (fifo_wen),
        .fifo_wdata (fifo_wdata)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int    total = 0;
    int    bad   = 0;
    string phase = "init";

    // Behavioural model: current owner (-1 when idle), last owner, beats accepted so far.
    int m_cur;
    int m_last;
    int m_beats;

    logic         cyc_wen;
    logic [W-1:0] cyc_wdata;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    always @(posedge wclk) begin
        if (wreset && fifo_wen) got_q.push_back(fifo_wdata);
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    function automatic bit has_req(input logic [NR-1:0] r, input int idx);
        return ((r >> idx) & NR'(1)) != '0;
    endfunction

    function automatic int pick(input int base, input logic [NR-1:0] r);
        for (int k = 1; k <= NR; k++) begin
            if (has_req(r, (base + k) % NR)) return (base + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_cur   = -1;
        m_last  = NR - 1;
        m_beats = 0;
    endtask

    task automatic model_edge(input logic [NR-1:0] r, input logic f);
        bit still;
        if (m_cur < 0) begin
            if (r != '0) m_cur = pick(m_last, r);
        end else begin
            still = has_req(r, m_cur);
            if (still && !f) m_beats++;
            if (!still || m_beats == MB) begin
                m_last  = m_cur;
                m_beats = 0;
                m_cur   = (r != '0) ? pick(m_cur, r) : -1;
            end
        end
    endtask

    // Called at a falling edge: drive inputs, compare outputs to the model, advance one edge.
    task automatic cyc(input logic [NR-1:0] r, input logic f);
        logic [NR-1:0] eg;
        logic [NR-1:0] ea;
        logic [W-1:0]  ed;
        req       = r;
        fifo_full = f;
        #1;
        eg = (m_cur < 0) ? '0 : NR'(1 << m_cur);
        ea = eg & r & {NR{~f}};
        ed = (m_cur < 0) ? '0 : W'(req_data >> (m_cur * W));
        check("gnt",   32'(gnt),        32'(eg));
        check("ack",   32'(ack),        32'(ea));
        check("wen",   32'(fifo_wen),   32'(|ea));
        check("busy",  32'(busy),       32'(|eg));
        check("wdata", 32'(fifo_wdata), 32'(ed));
        cyc_wen   = fifo_wen;
        cyc_wdata = fifo_wdata;
        if (ea != '0) exp_q.push_back(ed);
        @(posedge wclk);
        model_edge(r, f);
        @(negedge wclk);
    endtask

    // Called at a falling edge: hold reset across one rising edge, then release.
    task automatic do_reset(input logic [NR-1:0] r);
        wreset    = 1'b0;
        req       = r;
        fifo_full = 1'b0;
        #1;
        check("rst_gnt",   32'(gnt),        32'h0);
        check("rst_ack",   32'(ack),        32'h0);
        check("rst_wen",   32'(fifo_wen),   32'h0);
        check("rst_busy",  32'(busy),       32'h0);
        check("rst_wdata", 32'(fifo_wdata), 32'h0);
        @(negedge wclk);
        wreset = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [NR-1:0] r;
        int            wen_cnt;

        wreset    = 1'b0;
        req       = 4'b1111;
        fifo_full = 1'b0;
        req_data  = {4'hD, 4'hC, 4'hB, 4'hA};
        model_reset();
        @(negedge wclk);

        // T1: reset state, then first grant goes to requester 0.
        phase = "t1";
        do_reset(4'b1111);
        cyc(4'b1111, 1'b0);
        check("first_gnt", 32'(gnt), 32'h1);

        // T2 + T5: full rotation, four beats per requester, lane data follows the grant.
        phase = "t2";
        do_reset(4'b1111);
        cyc(4'b1111, 1'b0);
        wen_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            check("rot_gnt", 32'(gnt), 32'(1 << (k / 4)));
            cyc(4'b1111, 1'b0);
            check("rot_wdata", 32'(cyc_wdata), 32'(10 + k / 4));
            if (cyc_wen) wen_cnt++;
        end
        check("rot_beats", 32'(wen_cnt), 32'd16);
        check("rot_wrap", 32'(gnt), 32'h1);

        // T3: stall after one beat of lane 1; the burst cap ignores stall cycles.
        phase = "t3";
        do_reset(4'b1111);
        for (int k = 0; k < 6; k++) cyc(4'b1111, 1'b0);
        check("stall_gnt_pre", 32'(gnt), 32'h2);
        for (int k = 0; k < 3; k++) begin
            cyc(4'b1111, 1'b1);
            check("stall_wen", 32'(cyc_wen), 32'h0);
            check("stall_hold", 32'(gnt), 32'h2);
        end
        for (int k = 0; k < 3; k++) begin
            check("resume_gnt", 32'(gnt), 32'h2);
            cyc(4'b1111, 1'b0);
            check("resume_wen", 32'(cyc_wen), 32'h1);
        end
        check("stall_next", 32'(gnt), 32'h4);

        // T4: requester 2 drops after two beats; grant moves with no idle cycle.
        phase = "t4";
        do_reset(4'b1111);
        for (int k = 0; k < 9; k++) cyc(4'b1111, 1'b0);
        check("early_gnt_pre", 32'(gnt), 32'h4);
        cyc(4'b1111, 1'b0);
        cyc(4'b1111, 1'b0);
        cyc(4'b0001, 1'b0);
        check("early_drop_wen", 32'(cyc_wen), 32'h0);
        check("early_next", 32'(gnt), 32'h1);

        // T6: asynchronous reset in the middle of a lane-2 burst.
        phase = "t6";
        do_reset(4'b1111);
        for (int k = 0; k < 10; k++) cyc(4'b1111, 1'b0);
        check("mid_gnt_pre", 32'(gnt), 32'h4);
        req = 4'b1111;
        #2;
        wreset = 1'b0;
        #1;
        check("mid_gnt",   32'(gnt),        32'h0);
        check("mid_wen",   32'(fifo_wen),   32'h0);
        check("mid_busy",  32'(busy),       32'h0);
        check("mid_wdata", 32'(fifo_wdata), 32'h0);
        @(negedge wclk);
        wreset = 1'b1;
        model_reset();
        cyc(4'b1111, 1'b0);
        check("mid_restart", 32'(gnt), 32'h1);

        // Randomized traffic with random back-pressure and lane data.
        phase = "rand";
        do_reset(4'b0000);
        r = '0;
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 2) == 0) r = NR'($urandom_range(0, 15));
            req_data = (NR*W)'($urandom);
            cyc(r, $urandom_range(0, 3) == 0);
        end
        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b0);

        // Scoreboard: every beat the model accepted was written, in order, with the right data.
        phase = "sb";
        check("count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check("beat", 32'(got_q[i]), 32'(exp_q[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
